// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: digit data, load/brightness controls
// and the scanned anode/segment outputs.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    disp_en;
  logic [3:0]              bright;
  logic [6:0]              LED_out;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   Anode_activate;
  logic                    frame_tick;

  modport master (
    output digits_in, dp_in, load, disp_en, bright,
    input  LED_out, dp, Anode_activate, frame_tick
  );

  modport slave (
    input  digits_in, dp_in, load, disp_en, bright,
    output LED_out, dp, Anode_activate, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed seven-segment driver with double-buffered load, 16-level PWM
// and frame tick. Optional leading-zero blanking: define SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1600,
  parameter int ACTIVE_LOW  = 1
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);
  localparam int SUB_CNT = REFRESH_DIV / 16;
  localparam int SUB_W   = (SUB_CNT > 1) ? $clog2(SUB_CNT) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam logic [SUB_W-1:0]      SUB_LAST = SUB_W'(SUB_CNT - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [SUB_W-1:0]        sub_q, sub_d;
  logic [3:0]              phase_q, phase_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [6:0]              led_q, led_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q;

  logic                    sub_wrap, slot_end, frame_end;
  logic [3:0]              nib_sel;
  logic                    dp_sel, blank_sel, dp_on;
  logic [NUM_DIGITS-1:0]   an_sel, an_hi, lz_blank;
  logic [6:0]              seg_low;

  function automatic logic [6:0] seg_decode_low(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'b0000001;
      4'h1:    return 7'b1001111;
      4'h2:    return 7'b0010010;
      4'h3:    return 7'b0000110;
      4'h4:    return 7'b1001100;
      4'h5:    return 7'b0100100;
      4'h6:    return 7'b0100000;
      4'h7:    return 7'b0001111;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0000100;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b1100000;
      4'hC:    return 7'b0110001;
      4'hD:    return 7'b1000010;
      4'hE:    return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  always_comb begin
    sub_wrap  = (sub_q == SUB_LAST);
    slot_end  = sub_wrap && (phase_q == 4'hF);
    frame_end = slot_end && (idx_q == IDX_LAST);
    sub_d     = sub_wrap ? '0 : sub_q + 1'b1;
    phase_d   = sub_wrap ? phase_q + 4'd1 : phase_q;
    idx_d     = idx_q;
    if (slot_end) idx_d = frame_end ? '0 : idx_q + 1'b1;
    // Active reads the pre-load pending value, so a load on the boundary shows a frame later.
    act_dig_d  = frame_end ? pend_dig_q : act_dig_q;
    act_dp_d   = frame_end ? pend_dp_q  : act_dp_q;
    pend_dig_d = bus.load  ? bus.digits_in : pend_dig_q;
    pend_dp_d  = bus.load  ? bus.dp_in     : pend_dp_q;
  end

`ifdef SEG7_LZ_BLANK_EN
  logic lz_run;
  always_comb begin
    lz_run   = 1'b1;
    lz_blank = '0;
    for (int unsigned j = 0; j < NUM_DIGITS - 1; j++) begin
      lz_run = lz_run && (act_dig_q[4*(NUM_DIGITS-1-j) +: 4] == 4'h0)
                      && !act_dp_q[NUM_DIGITS-1-j];
      lz_blank[NUM_DIGITS-1-j] = lz_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    nib_sel   = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    an_sel    = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib_sel   = act_dig_q[4*k +: 4];
        dp_sel    = act_dp_q[k];
        blank_sel = lz_blank[k];
        an_sel[k] = 1'b1;
      end
    end
  end

  always_comb begin
    seg_low = blank_sel ? 7'h7F : seg_decode_low(nib_sel);
    dp_on   = dp_sel && !blank_sel;
    an_hi   = (bus.disp_en && (phase_q <= bus.bright)) ? an_sel : '0;
    led_d   = (ACTIVE_LOW != 0) ? seg_low : ~seg_low;
    dp_d    = (ACTIVE_LOW != 0) ? ~dp_on  : dp_on;
    an_d    = (ACTIVE_LOW != 0) ? ~an_hi  : an_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q      <= '0;
      phase_q    <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      act_dig_q  <= '0;
      act_dp_q   <= '0;
      led_q      <= SEG_OFF;
      dp_q       <= (ACTIVE_LOW != 0);
      an_q       <= AN_OFF;
      tick_q     <= 1'b0;
    end else begin
      sub_q      <= sub_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      act_dig_q  <= act_dig_d;
      act_dp_q   <= act_dp_d;
      led_q      <= led_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      tick_q     <= frame_end;
    end
  end

  assign bus.LED_out        = led_q;
  assign bus.dp             = dp_q;
  assign bus.Anode_activate = an_q;
  assign bus.frame_tick     = tick_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 16-clk slots, both polarities in lockstep.
module tb_seg7_scan_driver;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus_lo ();
  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus_hi ();

  assign bus_hi.digits_in = bus_lo.digits_in;
  assign bus_hi.dp_in     = bus_lo.dp_in;
  assign bus_hi.load      = bus_lo.load;
  assign bus_hi.disp_en   = bus_lo.disp_en;
  assign bus_hi.bright    = bus_lo.bright;

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(16), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_lo)
  );
  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(16), .ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .bus(bus_hi)
  );

  always #5 clk = ~clk;

  logic [6:0] led_slot [ND];
  logic [3:0] an_slot [ND];
  logic       dp_slot [ND];
  logic [6:0] hi_led_slot [ND];
  logic [3:0] hi_an_slot [ND];
  logic [6:0] last_led;
  int act_cnt, an0_cnt, tick_cnt, tick_at, led_chg, multi_hot, abcd_hits;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus_lo.frame_tick) seen = 1'b1;
    end
    if (!seen) check("tick_timeout", 0, 1);
  endtask

  // 64 samples = one frame; optionally pulses load with load_val after sample load_at.
  task automatic scan_frame(input int load_at, input logic [15:0] load_val);
    logic [6:0] prev;
    act_cnt = 0; an0_cnt = 0; tick_cnt = 0; tick_at = 0; led_chg = 0; multi_hot = 0;
    prev = bus_lo.LED_out;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (load_at > 0 && i == load_at + 1) bus_lo.load = 1'b0;
      if (bus_lo.Anode_activate != 4'hF) act_cnt++;
      if (bus_lo.Anode_activate == 4'hE) an0_cnt++;
      if ($countones(~bus_lo.Anode_activate) > 1) multi_hot++;
      if (bus_lo.frame_tick) begin tick_cnt++; tick_at = i; end
      if (bus_lo.LED_out != prev) led_chg++;
      prev = bus_lo.LED_out;
      if (bus_lo.LED_out inside {7'h08, 7'h60, 7'h31, 7'h42}) abcd_hits++;
      if ((i - 1) % 16 == 0) begin
        led_slot[(i-1)/16]    = bus_lo.LED_out;
        an_slot[(i-1)/16]     = bus_lo.Anode_activate;
        dp_slot[(i-1)/16]     = bus_lo.dp;
        hi_led_slot[(i-1)/16] = bus_hi.LED_out;
        hi_an_slot[(i-1)/16]  = bus_hi.Anode_activate;
      end
      if (i == 64) last_led = bus_lo.LED_out;
      if (i == load_at) begin
        bus_lo.load      = 1'b1;
        bus_lo.digits_in = load_val;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_lo.digits_in = '0;
    bus_lo.dp_in     = '0;
    bus_lo.load      = 1'b0;
    bus_lo.disp_en   = 1'b1;
    bus_lo.bright    = 4'hF;

    repeat (3) @(negedge clk);
    check("rst_an",      bus_lo.Anode_activate, 4'hF);
    check("rst_led",     bus_lo.LED_out, 7'h7F);
    check("rst_dp",      bus_lo.dp, 1'b1);
    check("rst_tick",    bus_lo.frame_tick, 1'b0);
    check("rst_hi_an",   bus_hi.Anode_activate, 4'h0);
    check("rst_hi_led",  bus_hi.LED_out, 7'h00);
    rst_n = 1'b1;

    @(negedge clk);
    check("an0_after_rst", bus_lo.Anode_activate, 4'hE);
    check("led_zero_init", bus_lo.LED_out, 7'h01);
    bus_lo.load      = 1'b1;
    bus_lo.digits_in = 16'h1234;
    @(negedge clk);
    bus_lo.load = 1'b0;

    wait_tick(100);
    check("led_before_swap", bus_lo.LED_out, 7'h01);
    scan_frame(0, 16'h0);
    check("d0_4",      led_slot[0], 7'h4C);
    check("d1_3",      led_slot[1], 7'h06);
    check("d2_2",      led_slot[2], 7'h12);
    check("d3_1",      led_slot[3], 7'h4F);
    check("an_d0",     an_slot[0], 4'hE);
    check("an_d3",     an_slot[3], 4'h7);
    check("an0_len",   an0_cnt, 16);
    check("tick_cnt",  tick_cnt, 1);
    check("tick_per",  tick_at, 64);
    check("onehot",    multi_hot, 0);

    // Load ABCD in the boundary cycle, then 5678 mid-frame.
    repeat (63) @(negedge clk);
    bus_lo.load      = 1'b1;
    bus_lo.digits_in = 16'hABCD;
    @(negedge clk);
    bus_lo.load = 1'b0;
    check("bnd_tick", bus_lo.frame_tick, 1'b1);
    check("bnd_led",  bus_lo.LED_out, 7'h4F);
    abcd_hits = 0;
    scan_frame(18, 16'h5678);
    check("old_kept_d0", led_slot[0], 7'h4C);
    check("old_last",    last_led, 7'h4F);
    check("tick_at_bnd", tick_at, 64);
    scan_frame(0, 16'h0);
    check("new_d0_8",  led_slot[0], 7'h00);
    check("new_d1_7",  led_slot[1], 7'h0F);
    check("new_d2_6",  led_slot[2], 7'h20);
    check("new_d3_5",  led_slot[3], 7'h24);
    check("no_abcd",   abcd_hits, 0);
    check("hi_led_8",  hi_led_slot[0], 7'h7F);
    check("hi_an_d0",  hi_an_slot[0], 4'h1);

    bus_lo.bright = 4'h0;
    scan_frame(0, 16'h0);
    check("pwm0_cnt",  act_cnt, 4);
    check("pwm0_an0",  an_slot[0], 4'hE);
    check("pwm0_an1",  an_slot[1], 4'hD);
    bus_lo.bright = 4'h7;
    scan_frame(0, 16'h0);
    check("pwm7_cnt",  act_cnt, 32);
    check("pwm7_hot",  multi_hot, 0);
    bus_lo.bright  = 4'hF;
    bus_lo.disp_en = 1'b0;
    scan_frame(0, 16'h0);
    check("dis_act",   act_cnt, 0);
    check("dis_led_chg", led_chg, 4);
    bus_lo.disp_en = 1'b1;

    bus_lo.load      = 1'b1;
    bus_lo.digits_in = 16'h0050;
    bus_lo.dp_in     = 4'b0000;
    @(negedge clk);
    bus_lo.load = 1'b0;
    wait_tick(100);
    scan_frame(0, 16'h0);
    check("lz_d0", led_slot[0], 7'h01);
    check("lz_d1", led_slot[1], 7'h24);
`ifdef SEG7_LZ_BLANK_EN
    check("lz_d2", led_slot[2], 7'h7F);
    check("lz_d3", led_slot[3], 7'h7F);
`else
    check("lz_d2", led_slot[2], 7'h01);
    check("lz_d3", led_slot[3], 7'h01);
`endif
    check("lz_dp3", dp_slot[3], 1'b1);

    bus_lo.load  = 1'b1;
    bus_lo.dp_in = 4'b1000;
    @(negedge clk);
    bus_lo.load = 1'b0;
    wait_tick(100);
    scan_frame(0, 16'h0);
    check("dp3_led", led_slot[3], 7'h01);
    check("dp3_on",  dp_slot[3], 1'b0);
    check("dp2_led", led_slot[2], 7'h01);
    check("dp2_off", dp_slot[2], 1'b1);

    // Asynchronous reset in the middle of a cycle.
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_an",     bus_lo.Anode_activate, 4'hF);
    check("mrst_led",    bus_lo.LED_out, 7'h7F);
    check("mrst_dp",     bus_lo.dp, 1'b1);
    check("mrst_tick",   bus_lo.frame_tick, 1'b0);
    check("mrst_hi_an",  bus_hi.Anode_activate, 4'h0);
    check("mrst_hi_dp",  bus_hi.dp, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_an0",    bus_lo.Anode_activate, 4'hE);
    check("mrst_led0",   bus_lo.LED_out, 7'h01);
    wait_tick(100);
    scan_frame(0, 16'h0);
    check("mrst_pend_clr", led_slot[3], 7'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
